// File: rtl/serial_monitor_if.sv
// serial_monitor_if
//   Bundles every signal between the monitor engine and its surroundings
//   (rx FIFO, UART transmitter, RAM monitor port, CPU control).
//   master : the monitor engine side
//   slave  : the SoC side (FIFOs, UART, RAM, CPU)
//   ADDR_WIDTH sets the width of all RAM / CPU address signals.
interface serial_monitor_if #(
    parameter int ADDR_WIDTH = 13
);
    logic                  rx_empty;
    logic [7:0]            rx_data;
    logic                  rx_read;
    logic                  tx_busy;
    logic [7:0]            tx_byte;
    logic                  tx_start;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [7:0]            mem_rdata;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [7:0]            mem_wdata;
    logic                  mem_write;
    logic                  cpu_start;
    logic [ADDR_WIDTH-1:0] cpu_start_addr;
    logic                  cpu_halted;
    logic                  running;
    logic                  err;

    modport master (
        input  rx_empty, rx_data, tx_busy, mem_rdata, cpu_halted,
        output rx_read, tx_byte, tx_start, mem_raddr, mem_waddr, mem_wdata,
               mem_write, cpu_start, cpu_start_addr, running, err
    );

    modport slave (
        output rx_empty, rx_data, tx_busy, mem_rdata, cpu_halted,
        input  rx_read, tx_byte, tx_start, mem_raddr, mem_waddr, mem_wdata,
               mem_write, cpu_start, cpu_start_addr, running, err
    );
endinterface

// File: rtl/serial_monitor.sv
// serial_monitor
//   UART monitor engine. Parses 5-byte command frames (cmd, addr_hi, addr_lo,
//   len_hi, len_lo) from a show-ahead receive FIFO and runs LOAD / DUMP /
//   EXEC / FILL against the RAM monitor port, answering each command with a
//   status byte (A5 ok, 5A checksum error, EE unknown command).
// Ports
//   CLK    : clock
//   reset  : synchronous, active-low
//   bus    : serial_monitor_if.master (rx FIFO, UART tx, RAM port, CPU control)
// Parameters
//   ADDR_WIDTH : RAM address width (header address truncated to it)
//   TX_GAP     : idle cycles enforced after every tx_start (>= 2)
//   ECHO       : echo each header byte before parsing continues
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | wait for a byte in the rx FIFO
// HDR        | pop 5 header bytes, echoing each one when ECHO is set
// DISPATCH   | latch address/length, clear checksum, branch on command
// LOAD_BYTE  | pop payload bytes, write each to RAM
// LOAD_CHK   | pop checksum byte, choose status
// DUMP_ADDR  | RAM address presented (or go send checksum when done)
// DUMP_WAIT  | capture RAM read data
// DUMP_SEND  | transmit the captured byte
// DUMP_CHK   | transmit the checksum
// FILL_GET   | pop the fill byte
// FILL_WR    | one write per cycle for len cycles
// RUN        | CPU running, wait for cpu_halted
// STATUS     | transmit the status byte, update err
module serial_monitor #(
    parameter int          ADDR_WIDTH = 13,
    parameter logic [15:0] TX_GAP     = 16'h0fff,
    parameter bit          ECHO       = 1'b1
) (
    input logic              CLK,
    input logic              reset,
    serial_monitor_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_DISPATCH,
        S_LOAD_BYTE, S_LOAD_CHK,
        S_DUMP_ADDR, S_DUMP_WAIT, S_DUMP_SEND, S_DUMP_CHK,
        S_FILL_GET, S_FILL_WR,
        S_RUN, S_STATUS
    } state_t;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_DUMP = 8'h02;
    localparam logic [7:0] CMD_EXEC = 8'h03;
    localparam logic [7:0] CMD_FILL = 8'h04;
    localparam logic [7:0] ST_OK    = 8'hA5;
    localparam logic [7:0] ST_CSUM  = 8'h5A;
    localparam logic [7:0] ST_UNK   = 8'hEE;

    state_t      state, state_n;
    logic [39:0] hdr, hdr_n;
    logic [2:0]  hdr_cnt, hdr_cnt_n;
    logic        echo_pend, echo_pend_n;
    logic        rx_wait, rx_wait_n;
    addr_t       addr, addr_n;
    logic [15:0] cnt, cnt_n;
    logic [7:0]  csum, csum_n;
    logic [7:0]  data, data_n;
    logic [7:0]  status, status_n;
    logic [1:0]  hold, hold_n;
    logic [15:0] gap, gap_n;

    logic [7:0]  tx_byte_q, tx_byte_n;
    logic        tx_start_q, tx_start_n;
    addr_t       raddr_q, raddr_n;
    addr_t       waddr_q, waddr_n;
    logic [7:0]  wdata_q, wdata_n;
    logic        write_q, write_n;
    logic        cpu_start_q, cpu_start_n;
    addr_t       cpu_addr_q, cpu_addr_n;
    logic        running_q, running_n;
    logic        err_q, err_n;

    logic        rx_read;
    logic        rx_ok;
    logic        tx_ready;
    logic        tx_go;
    logic [7:0]  tx_val;
    logic [7:0]  hdr_cmd;
    addr_t       hdr_addr;
    logic [15:0] hdr_len;
    logic        unused_hdr;

    assign hdr_cmd    = hdr[39:32];
    assign hdr_addr   = addr_t'(hdr[31:16]);
    assign hdr_len    = hdr[15:0];
    assign unused_hdr = ^hdr[31:16];

    // The FIFO flag is stale in the cycle after a pop, so it is not trusted then.
    assign rx_ok    = !bus.rx_empty && !rx_wait;
    // tx_start_q covers the cycle before the UART reports busy.
    assign tx_ready = !bus.tx_busy && (gap == 16'd0) && !tx_start_q;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state       <= S_IDLE;
            hdr         <= '0;
            hdr_cnt     <= '0;
            echo_pend   <= 1'b0;
            rx_wait     <= 1'b0;
            addr        <= '0;
            cnt         <= '0;
            csum        <= '0;
            data        <= '0;
            status      <= '0;
            hold        <= '0;
            gap         <= '0;
            tx_byte_q   <= '0;
            tx_start_q  <= 1'b0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            cpu_start_q <= 1'b0;
            cpu_addr_q  <= '0;
            running_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_n;
            hdr         <= hdr_n;
            hdr_cnt     <= hdr_cnt_n;
            echo_pend   <= echo_pend_n;
            rx_wait     <= rx_wait_n;
            addr        <= addr_n;
            cnt         <= cnt_n;
            csum        <= csum_n;
            data        <= data_n;
            status      <= status_n;
            hold        <= hold_n;
            gap         <= gap_n;
            tx_byte_q   <= tx_byte_n;
            tx_start_q  <= tx_start_n;
            raddr_q     <= raddr_n;
            waddr_q     <= waddr_n;
            wdata_q     <= wdata_n;
            write_q     <= write_n;
            cpu_start_q <= cpu_start_n;
            cpu_addr_q  <= cpu_addr_n;
            running_q   <= running_n;
            err_q       <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        hdr_n       = hdr;
        hdr_cnt_n   = hdr_cnt;
        echo_pend_n = echo_pend;
        addr_n      = addr;
        cnt_n       = cnt;
        csum_n      = csum;
        data_n      = data;
        status_n    = status;
        hold_n      = hold;
        tx_byte_n   = tx_byte_q;
        tx_start_n  = 1'b0;
        raddr_n     = raddr_q;
        waddr_n     = waddr_q;
        wdata_n     = wdata_q;
        write_n     = 1'b0;
        cpu_start_n = 1'b0;
        cpu_addr_n  = cpu_addr_q;
        running_n   = running_q;
        err_n       = err_q;
        rx_read     = 1'b0;
        tx_go       = 1'b0;
        tx_val      = 8'h00;

        case (state)
            S_IDLE: begin
                hdr_cnt_n   = 3'd0;
                echo_pend_n = 1'b0;
                if (rx_ok) state_n = S_HDR;
            end
            S_HDR: begin
                if (echo_pend) begin
                    if (tx_ready) begin
                        tx_go       = 1'b1;
                        tx_val      = hdr[7:0];
                        echo_pend_n = 1'b0;
                    end
                end else if (hdr_cnt == 3'd5) begin
                    state_n = S_DISPATCH;
                end else if (rx_ok) begin
                    rx_read     = 1'b1;
                    hdr_n       = {hdr[31:0], bus.rx_data};
                    hdr_cnt_n   = hdr_cnt + 3'd1;
                    echo_pend_n = ECHO;
                end
            end
            S_DISPATCH: begin
                csum_n  = 8'h00;
                addr_n  = hdr_addr;
                raddr_n = hdr_addr;
                cnt_n   = hdr_len;
                case (hdr_cmd)
                    CMD_LOAD: state_n = S_LOAD_BYTE;
                    CMD_DUMP: state_n = S_DUMP_ADDR;
                    CMD_FILL: state_n = S_FILL_GET;
                    CMD_EXEC: begin
                        cpu_addr_n  = hdr_addr;
                        cpu_start_n = 1'b1;
                        running_n   = 1'b1;
                        // cpu_halted is ignored in the start cycle and the one after
                        hold_n      = 2'd2;
                        state_n     = S_RUN;
                    end
                    default: begin
                        status_n = ST_UNK;
                        state_n  = S_STATUS;
                    end
                endcase
            end
            S_LOAD_BYTE: begin
                if (cnt == 16'd0) begin
                    state_n = S_LOAD_CHK;
                end else if (rx_ok) begin
                    rx_read = 1'b1;
                    write_n = 1'b1;
                    waddr_n = addr;
                    wdata_n = bus.rx_data;
                    csum_n  = csum + bus.rx_data;
                    addr_n  = addr + addr_t'(1);
                    cnt_n   = cnt - 16'd1;
                end
            end
            S_LOAD_CHK: begin
                if (rx_ok) begin
                    rx_read  = 1'b1;
                    status_n = (bus.rx_data == csum) ? ST_OK : ST_CSUM;
                    state_n  = S_STATUS;
                end
            end
            S_DUMP_ADDR: begin
                state_n = (cnt == 16'd0) ? S_DUMP_CHK : S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
                data_n  = bus.mem_rdata;
                csum_n  = csum + bus.mem_rdata;
                cnt_n   = cnt - 16'd1;
                state_n = S_DUMP_SEND;
            end
            S_DUMP_SEND: begin
                if (tx_ready) begin
                    tx_go   = 1'b1;
                    tx_val  = data;
                    raddr_n = raddr_q + addr_t'(1);
                    state_n = S_DUMP_ADDR;
                end
            end
            S_DUMP_CHK: begin
                if (tx_ready) begin
                    tx_go    = 1'b1;
                    tx_val   = csum;
                    status_n = ST_OK;
                    state_n  = S_STATUS;
                end
            end
            S_FILL_GET: begin
                if (rx_ok) begin
                    rx_read = 1'b1;
                    wdata_n = bus.rx_data;
                    state_n = S_FILL_WR;
                end
            end
            S_FILL_WR: begin
                if (cnt == 16'd0) begin
                    status_n = ST_OK;
                    state_n  = S_STATUS;
                end else begin
                    write_n = 1'b1;
                    waddr_n = addr;
                    addr_n  = addr + addr_t'(1);
                    cnt_n   = cnt - 16'd1;
                end
            end
            S_RUN: begin
                if (hold != 2'd0) begin
                    hold_n = hold - 2'd1;
                end else if (bus.cpu_halted) begin
                    running_n = 1'b0;
                    status_n  = ST_OK;
                    state_n   = S_STATUS;
                end
            end
            S_STATUS: begin
                if (tx_ready) begin
                    tx_go   = 1'b1;
                    tx_val  = status;
                    err_n   = (status != ST_OK);
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        rx_wait_n = rx_read;

        if (tx_go) begin
            tx_start_n = 1'b1;
            tx_byte_n  = tx_val;
        end

        // Gap counter holds TX_GAP during the tx_start cycle, then counts down.
        if (tx_go)
            gap_n = TX_GAP;
        else if (gap != 16'd0)
            gap_n = gap - 16'd1;
        else
            gap_n = gap;
    end

    assign bus.rx_read        = rx_read;
    assign bus.tx_byte        = tx_byte_q;
    assign bus.tx_start       = tx_start_q;
    assign bus.mem_raddr      = raddr_q;
    assign bus.mem_waddr      = waddr_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.mem_write      = write_q;
    assign bus.cpu_start      = cpu_start_q;
    assign bus.cpu_start_addr = cpu_addr_q;
    assign bus.running        = running_q;
    assign bus.err            = err_q;
endmodule

// File: tb/tb_serial_monitor.sv
// tb_serial_monitor
//   Directed bench for serial_monitor: show-ahead rx FIFO model, UART busy
//   model, 1-cycle-latency RAM model, hand-written expected tx stream.
module tb_serial_monitor;
    localparam int          AW          = 13;
    localparam logic [15:0] GAP         = 16'd8;
    localparam int          BUSY_CYCLES = 12;

    logic CLK   = 1'b0;
    logic reset = 1'b0;

    serial_monitor_if #(.ADDR_WIDTH(AW)) bus ();

    serial_monitor #(.ADDR_WIDTH(AW), .TX_GAP(GAP), .ECHO(1'b1)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] fifo_mem [256];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] ram [8192];
    logic [7:0] txlog [256];
    int         txn = 0;
    int         cyc = 0;
    int         last_tx_cyc = 0;
    int         gap_viol = 0;
    int         busy_viol = 0;
    int         empty_pop = 0;
    int         run_pop = 0;
    int         busy_cnt = 0;
    int         cpu_start_cycles = 0;
    logic [AW-1:0] wlog_addr [64];
    logic [7:0]    wlog_data [64];
    int            wlog_cyc  [64];
    int            wcount = 0;
    logic [7:0]    exp_q [$];
    int            tx_chk = 0;

    assign bus.rx_empty = (rd_ptr == wr_ptr);
    assign bus.rx_data  = fifo_mem[rd_ptr[7:0]];
    assign bus.tx_busy  = (busy_cnt != 0);

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        if (bus.rx_read) begin
            if (rd_ptr == wr_ptr) empty_pop <= empty_pop + 1;
            if (bus.running) run_pop <= run_pop + 1;
            rd_ptr <= rd_ptr + 1;
        end
    end

    always @(posedge CLK) begin
        if (bus.tx_start) begin
            if (txn > 0 && (cyc - last_tx_cyc) < int'(GAP)) gap_viol <= gap_viol + 1;
            if (bus.tx_busy) busy_viol <= busy_viol + 1;
            if (txn < 256) txlog[txn] <= bus.tx_byte;
            txn         <= txn + 1;
            last_tx_cyc <= cyc;
            busy_cnt    <= BUSY_CYCLES;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    always @(posedge CLK) begin
        bus.mem_rdata <= ram[bus.mem_raddr];
        if (bus.mem_write) begin
            ram[bus.mem_waddr] = bus.mem_wdata;
            if (wcount < 64) begin
                wlog_addr[wcount] <= bus.mem_waddr;
                wlog_data[wcount] <= bus.mem_wdata;
                wlog_cyc[wcount]  <= cyc;
            end
            wcount <= wcount + 1;
        end
        if (bus.cpu_start) cpu_start_cycles <= cpu_start_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    // Header bytes are echoed, so each one is also an expected tx byte.
    task automatic hdr(input logic [7:0] c, input logic [7:0] ah, input logic [7:0] al,
                       input logic [7:0] lh, input logic [7:0] ll);
        push(c);  exp_q.push_back(c);
        push(ah); exp_q.push_back(ah);
        push(al); exp_q.push_back(al);
        push(lh); exp_q.push_back(lh);
        push(ll); exp_q.push_back(ll);
    endtask

    task automatic wait_stream(input string tag);
        int budget;
        budget = 5000;
        while (txn < exp_q.size() && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        repeat (40) @(negedge CLK);
        check({tag, "_count"}, txn, exp_q.size());
        for (int i = tx_chk; i < exp_q.size() && i < txn; i++)
            check({tag, "_byte"}, txlog[i], exp_q[i]);
        tx_chk = exp_q.size();
    endtask

    initial begin
        int budget;
        int w0;
        int rd_snap;

        bus.cpu_halted = 1'b0;
        for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
        ram[13'h1FFE] = 8'hC1;
        ram[13'h1FFF] = 8'hC2;
        ram[13'h0000] = 8'hC3;
        ram[13'h0001] = 8'hC4;

        repeat (3) @(negedge CLK);
        check("rst_rx_read",   bus.rx_read,        0);
        check("rst_tx_start",  bus.tx_start,       0);
        check("rst_tx_byte",   bus.tx_byte,        0);
        check("rst_mem_write", bus.mem_write,      0);
        check("rst_mem_raddr", bus.mem_raddr,      0);
        check("rst_mem_waddr", bus.mem_waddr,      0);
        check("rst_mem_wdata", bus.mem_wdata,      0);
        check("rst_cpu_start", bus.cpu_start,      0);
        check("rst_cpu_addr",  bus.cpu_start_addr, 0);
        check("rst_running",   bus.running,        0);
        check("rst_err",       bus.err,            0);
        reset = 1'b1;
        repeat (2) @(negedge CLK);

        // LOAD with good checksum
        hdr(8'h01, 8'h00, 8'h10, 8'h00, 8'h03);
        push(8'h11); push(8'h22); push(8'h33); push(8'h66);
        exp_q.push_back(8'hA5);
        wait_stream("load_ok");
        check("load_ok_ram10", ram[13'h010], 8'h11);
        check("load_ok_ram11", ram[13'h011], 8'h22);
        check("load_ok_ram12", ram[13'h012], 8'h33);
        check("load_ok_err",   bus.err,      0);

        // LOAD with bad checksum: data still written, status 5A
        hdr(8'h01, 8'h00, 8'h10, 8'h00, 8'h03);
        push(8'h44); push(8'h55); push(8'h66); push(8'h00);
        exp_q.push_back(8'h5A);
        wait_stream("load_bad");
        check("load_bad_ram10", ram[13'h010], 8'h44);
        check("load_bad_ram12", ram[13'h012], 8'h66);
        check("load_bad_err",   bus.err,      1);

        // DUMP across the address wrap; C1+C2+C3+C4 = 0x30A
        hdr(8'h02, 8'h1F, 8'hFE, 8'h00, 8'h04);
        exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
        exp_q.push_back(8'hC3); exp_q.push_back(8'hC4);
        exp_q.push_back(8'h0A); exp_q.push_back(8'hA5);
        wait_stream("dump");
        check("dump_err_cleared", bus.err, 0);

        // FILL five bytes
        w0 = wcount;
        hdr(8'h04, 8'h00, 8'h20, 8'h00, 8'h05);
        push(8'hAB);
        exp_q.push_back(8'hA5);
        wait_stream("fill");
        check("fill_nwrites", wcount, w0 + 5);
        for (int k = 0; k < 5; k++) begin
            check("fill_addr", wlog_addr[w0 + k], 32'h20 + k);
            check("fill_data", wlog_data[w0 + k], 8'hAB);
            check("fill_consec", wlog_cyc[w0 + k] - wlog_cyc[w0], k);
        end
        check("fill_ram25", ram[13'h025], 8'h00);

        // EXEC at 0x100; a byte arriving while running must stay in the FIFO
        hdr(8'h03, 8'h01, 8'h00, 8'h00, 8'h00);
        budget = 3000;
        while (!bus.cpu_start && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        check("exec_start_seen", bus.cpu_start,      1);
        check("exec_start_addr", bus.cpu_start_addr, 32'h100);
        check("exec_running",    bus.running,        1);
        push(8'h07);
        rd_snap = rd_ptr;
        @(negedge CLK);
        check("exec_start_pulse", bus.cpu_start, 0);
        repeat (50) @(negedge CLK);
        check("exec_no_pop",     rd_ptr,      rd_snap);
        check("exec_still_run",  bus.running, 1);
        bus.cpu_halted = 1'b1;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h07);
        wait_stream("exec");
        check("exec_running_done", bus.running, 0);
        check("exec_cpu_addr_hold", bus.cpu_start_addr, 32'h100);
        bus.cpu_halted = 1'b0;

        // Unknown command 07 (first byte already queued above)
        push(8'h00); exp_q.push_back(8'h00);
        push(8'h00); exp_q.push_back(8'h00);
        push(8'h00); exp_q.push_back(8'h00);
        push(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'hEE);
        wait_stream("unknown");
        check("unknown_err", bus.err, 1);

        // Reset in the middle of a DUMP: two data bytes out, then nothing
        hdr(8'h02, 8'h00, 8'h10, 8'h00, 8'h08);
        exp_q.push_back(8'h44); exp_q.push_back(8'h55);
        budget = 3000;
        while (txn < exp_q.size() && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        reset = 1'b0;
        @(negedge CLK);
        check("midrst_tx_start", bus.tx_start, 0);
        check("midrst_running",  bus.running,  0);
        check("midrst_err",      bus.err,      0);
        @(negedge CLK);
        reset = 1'b1;
        repeat (100) @(negedge CLK);
        wait_stream("midrst");

        // len = 0 variants of LOAD, DUMP and FILL
        w0 = wcount;
        hdr(8'h01, 8'h00, 8'h30, 8'h00, 8'h00);
        push(8'h00);
        exp_q.push_back(8'hA5);
        hdr(8'h02, 8'h00, 8'h00, 8'h00, 8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'hA5);
        hdr(8'h04, 8'h00, 8'h40, 8'h00, 8'h00);
        push(8'h5C);
        exp_q.push_back(8'hA5);
        wait_stream("len0");
        check("len0_no_writes", wcount, w0);
        check("len0_fifo_drained", rd_ptr, wr_ptr);
        check("len0_err", bus.err, 0);

        check("gap_violations",  gap_viol,  0);
        check("busy_violations", busy_viol, 0);
        check("pop_when_empty",  empty_pop, 0);
        check("pop_when_running", run_pop,  0);
        check("cpu_start_cycles", cpu_start_cycles, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
